// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative RV32M DIV/DIVU/REM/REMU unit for the execute stage
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      div_op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            ex_stall_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_req_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state;
  logic            op_rem;
  logic            neg_quo;
  logic            neg_rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;

  logic            is_signed;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic            div_zero;
  logic            overflow;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;

  // Operand preparation: magnitudes and sign fix-up flags for signed ops
  always_comb begin
    is_signed    = ~div_op_i[0];
    dividend_neg = is_signed & dividend_i[XLEN-1];
    divisor_neg  = is_signed & divisor_i[XLEN-1];
    dividend_abs = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
    divisor_abs  = divisor_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero     = (divisor_i == '0);
    overflow     = is_signed & (dividend_i == MIN_NEG) & (divisor_i == ALL_ONES);
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  always_comb begin
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, dsr});
    rem_nx  = rem_ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
    quo_nx  = {quo[XLEN-2:0], rem_ge};
    quo_fin = neg_quo ? (~quo_nx + 1'b1) : quo_nx;
    rem_fin = neg_rem ? (~rem_nx[XLEN-1:0] + 1'b1) : rem_nx[XLEN-1:0];
  end

  // Stall the front of the pipe while a divide is in EX and has no result yet
  always_comb begin
    stall_req_o = start_i & ~done_o & ~flush_i;
  end

  // Control FSM with datapath registers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_rem    <= 1'b0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      quo       <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_rem    <= div_op_i[1];
            rd_addr_o <= rd_addr_i;
            neg_quo   <= dividend_neg ^ divisor_neg;
            neg_rem   <= dividend_neg;
            quo       <= dividend_abs;
            dsr       <= divisor_abs;
            rem       <= '0;
            cnt       <= '0;
            if (div_zero) begin
              result_o <= div_op_i[1] ? dividend_i : ALL_ONES;
              state    <= S_DONE;
              done_o   <= 1'b1;
            end else if (overflow) begin
              result_o <= div_op_i[1] ? '0 : MIN_NEG;
              state    <= S_DONE;
              done_o   <= 1'b1;
            end else begin
              state  <= S_CALC;
              busy_o <= 1'b1;
            end
          end
        end
        S_CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (cnt == LAST_CNT) begin
            cnt      <= '0;
            result_o <= op_rem ? rem_fin : quo_fin;
            state    <= S_DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!ex_stall_i) begin
            state  <= S_IDLE;
            done_o <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - randomized self-checking bench for ex_div
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd_addr = '0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        done;
  logic        busy;
  logic        stall_req;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_result = '0;
  logic [4:0]  exp_rd = '0;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .div_op_i(div_op),
    .dividend_i(dividend), .divisor_i(divisor), .rd_addr_i(rd_addr),
    .ex_stall_i(ex_stall), .flush_i(flush), .result_o(result),
    .rd_addr_o(rd_out), .done_o(done), .busy_o(busy), .stall_req_o(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Every cycle: stall request equation, and result/rd whenever done is high
  always @(negedge clk) begin
    if (!rst) begin
      check("stall_req", {31'd0, stall_req}, {31'd0, start & ~done & ~flush});
      check("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        check("result", result, exp_result);
        check("rd_addr", {27'd0, rd_out}, {27'd0, exp_rd});
      end
    end
  end

  // Issue one divide from an IDLE cycle (called just after a rising edge)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold,
                        input logic use_lit, input logic [31:0] lit);
    int lat;
    int busy_cnt;
    int exp_lat;
    start      = 1'b1;
    div_op     = op;
    dividend   = a;
    divisor    = b;
    rd_addr    = rd;
    exp_result = ref_div(op, a, b);
    exp_rd     = rd;
    exp_lat    = ref_latency(op, a, b);
    lat        = 0;
    busy_cnt   = 0;
    @(negedge clk);
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_busy_low", {31'd0, busy}, 32'd0);
    while (!done) begin
      lat++;
      if (lat > 40) begin
        check("done_timeout", 32'(lat), 32'(exp_lat));
        break;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), (exp_lat == 33) ? 32'd32 : 32'd0);
    if (use_lit) check("literal", result, lit);
    ex_stall = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_held", {31'd0, done}, 32'd1);
      if (i == hold - 1) ex_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    // Reset state
    #2;
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases with hand-computed results
    run_op(2'd1, 32'd100, 32'd7, 5'd3, 3, 1'b1, 32'd14);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1'b1, 32'hFFFF_FFFD);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b1, 32'd1);
    run_op(2'd0, 32'd5, 32'd0, 5'd7, 0, 1'b1, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd5, 32'd0, 5'd8, 2, 1'b1, 32'd5);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 1'b1, 32'h8000_0000);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 1'b1, 32'd0);
    run_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b1, 32'd0);

    // Flush at CALC cycle 10
    start    = 1'b1;
    div_op   = 2'd1;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd13;
    rd_addr  = 5'd12;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    check("flush_stall_low", {31'd0, stall_req}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_stall", {31'd0, stall_req}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) check("flush_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    run_op(2'd1, 32'd9, 32'd3, 5'd13, 0, 1'b1, 32'd3);

    // Randomized back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      else if (sel == 4) a = 32'($urandom_range(0, 100));
      run_op(op, a, b, 5'($urandom), $urandom_range(0, 2), 1'b0, 32'd0);
    end

    // Asynchronous reset in the middle of CALC
    start    = 1'b1;
    div_op   = 2'd0;
    dividend = 32'd1000;
    divisor  = 32'd7;
    rd_addr  = 5'd21;
    repeat (6) @(posedge clk);
    #3;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_rd", {27'd0, rd_out}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(2'd3, 32'd1000, 32'd7, 5'd22, 1, 1'b1, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions, living in the execute stage directly downstream of the ID/EX pipeline register. It consumes the operand, decode and destination fields that register presents and computes one quotient bit per cycle. While it works it holds the pipeline through a stall request to ctrl, then returns the result with its destination address for EX writeback muxing.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  a divide instruction occupies EX; held high until it leaves EX
- div_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  in  XLEN  op1 from ID/EX
- divisor_i  in  XLEN  op2 from ID/EX
- rd_addr_i  in  5  destination register
- ex_stall_i  in  1  EX held by a later stage (ctrl stall bit for EX)
- flush_i  in  1  EX flushed by ctrl
- result_o  out  XLEN  quotient or remainder, valid when done_o
- rd_addr_o  out  5  captured destination
- done_o  out  1  result valid
- busy_o  out  1  state is CALC
- stall_req_o  out  1  to ctrl; freeze IF/ID/EX

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start_i=1 and flush_i=0: capture op, rd_addr, operand signs, |dividend|, |divisor| (signed ops only; unsigned ops take raw values); clear the 6-bit counter and the 33-bit partial remainder.
  - If divisor==0: go to DONE. Quotient = 0xFFFFFFFF. Remainder = dividend.
  - If signed and dividend==0x80000000 and divisor==0xFFFFFFFF: go to DONE. Quotient = 0x80000000. Remainder = 0.
  - Otherwise: go to CALC.
- CALC, each edge does one restoring step:
  - rem = {rem[31:0], q[31]}; q <<= 1.
  - If rem >= divisor: rem -= divisor and set q[0].
  - The counter increments. The edge with counter==31 does the last step and moves to DONE.
- Entering DONE from CALC:
  - Negate the quotient if the signed op has operand signs that differ.
  - Negate the remainder if the signed op has a negative dividend.
  - result_o selects the quotient for DIV/DIVU and the remainder for REM/REMU. It is registered and stable throughout DONE.
- DONE: if ex_stall_i=1, stay in DONE and keep result_o and done_o. Otherwise go to IDLE.
- flush_i=1 in any state: go to IDLE on the next edge, drop the result, and start nothing that cycle. Flush has priority over start and over ex_stall_i.
- stall_req_o = start_i & ~done_o & ~flush_i (combinational).
- done_o = (state==DONE); busy_o = (state==CALC).
- Reset values: state IDLE; result_o 0, rd_addr_o 0, done_o 0, busy_o 0; internal registers 0. stall_req_o follows its equation and is therefore 0 when start_i is 0.

## Timing
- E0 is the edge that samples start_i in IDLE.
- Normal case: CALC occupies the 32 cycles after E0. done_o rises after edge E32, so the result is available 33 cycles after the start cycle. The stall is released in that same cycle, and the instruction leaves EX on the next edge.
- Special cases (divide by zero, overflow): done_o is high in the cycle after E0, one cycle of latency.
- Back-to-back divides: the block returns to IDLE after DONE, and the next instruction's start_i is sampled in the following cycle. No bubble is needed beyond the IDLE cycle.
- Operand inputs are ignored outside IDLE. The ID/EX register is frozen by stall_req_o in any case.
- Asynchronous rst mid-CALC: the block is in IDLE immediately, with all outputs at their reset values. No partial result is ever presented.
- Counter wrap: the counter never exceeds 31. It is cleared on every entry to CALC.

## Test plan
- DIVU 100 / 7 -> result_o=14 and done_o high exactly 33 cycles after the start cycle. stall_req_o is high for the 32 preceding cycles.
- REM -7 / 2 -> result_o=0xFFFFFFFF (-1). DIV -7 / 2 -> 0xFFFFFFFD (-3). REMU 0xFFFFFFF9 / 2 -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. Both with done_o high one cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. Both in one cycle.
- flush_i pulsed at CALC cycle 10:
  - Next cycle: state IDLE, done_o never asserted, stall_req_o=0.
  - A new DIVU 9 / 3 afterwards -> 3.
- ex_stall_i high for 3 cycles during DONE -> done_o and result_o held for 4 cycles and no restart occurs. rst asserted mid-CALC -> all outputs 0 asynchronously.
